// File: rtl/issue_sched.sv
// issue_sched: selects at most one of four functional-unit queues to issue
// each cycle. It also schedules the result of each issued instruction onto a
// single shared common data bus (CDB) so that no two results ever collide.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   ready_int/ld_buf/mult/div   queue has an instruction ready to issue
//   rdtag                       destination tag of the instruction issued now
//   int/ld_buf/mult/div_data    unit results, valid in their CDB cycle
//   issue_int/ld_buf/mult/div   one-hot (or zero) combinational issue grant
//   issue_div_done              divide result is on the CDB this cycle
//   cdb_valid/cdb_out/cdb_tagout  registered CDB broadcast (zeroed when idle)
module issue_sched #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready_int,
    input  logic              ready_ld_buf,
    input  logic              ready_mult,
    input  logic              ready_div,
    input  logic [TAG_W-1:0]  rdtag,
    input  logic [DATA_W-1:0] int_data,
    input  logic [DATA_W-1:0] ld_buf_data,
    input  logic [DATA_W-1:0] mult_data,
    input  logic [DATA_W-1:0] div_data,
    output logic              issue_int,
    output logic              issue_ld_buf,
    output logic              issue_mult,
    output logic              issue_div,
    output logic              issue_div_done,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_out,
    output logic [TAG_W-1:0]  cdb_tagout
);

    typedef enum logic [1:0] {
        SRC_INT  = 2'd0,
        SRC_LD   = 2'd1,
        SRC_MULT = 2'd2,
        SRC_DIV  = 2'd3
    } src_t;

    localparam int unsigned CNT_W = $clog2(DIV_LAT);

    // Slot k describes the CDB cycle k cycles from now.
    logic             busy [0:DIV_LAT];
    src_t             src  [0:DIV_LAT];
    logic [TAG_W-1:0] tag  [0:DIV_LAT];

    logic [CNT_W-1:0] div_cnt;
    logic             prefer_ld;

    logic elig_int, elig_ld, elig_mult, elig_div;

    // A unit of latency L may issue only if CDB slot L is still free.
    always_comb begin
        elig_int   = ready_int    && !busy[1];
        elig_ld    = ready_ld_buf && !busy[1];
        elig_mult  = ready_mult   && !busy[MULT_LAT];
        elig_div   = ready_div    && !busy[DIV_LAT] && (div_cnt == '0);

        issue_int    = 1'b0;
        issue_ld_buf = 1'b0;
        issue_mult   = 1'b0;
        issue_div    = 1'b0;

        if (!reset) begin
            if (elig_div) begin
                issue_div = 1'b1;
            end else if (elig_mult) begin
                issue_mult = 1'b1;
            end else if (elig_int && elig_ld) begin
                if (prefer_ld) issue_ld_buf = 1'b1;
                else           issue_int    = 1'b1;
            end else if (elig_int) begin
                issue_int = 1'b1;
            end else if (elig_ld) begin
                issue_ld_buf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k <= DIV_LAT; k++) begin
                busy[k] <= 1'b0;
                src[k]  <= SRC_INT;
                tag[k]  <= '0;
            end
            div_cnt   <= '0;
            prefer_ld <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < DIV_LAT; k++) begin
                busy[k] <= busy[k+1];
                src[k]  <= src[k+1];
                tag[k]  <= tag[k+1];
            end
            busy[DIV_LAT] <= 1'b0;
            src[DIV_LAT]  <= SRC_INT;
            tag[DIV_LAT]  <= '0;

            // Grant writes land on slot L-1 because the vector shifts on the
            // same edge; they override the shifted-in (known free) slot L.
            if (issue_int || issue_ld_buf) begin
                busy[0]   <= 1'b1;
                src[0]    <= issue_int ? SRC_INT : SRC_LD;
                tag[0]    <= rdtag;
                prefer_ld <= issue_int;
            end
            if (issue_mult) begin
                busy[MULT_LAT-1] <= 1'b1;
                src[MULT_LAT-1]  <= SRC_MULT;
                tag[MULT_LAT-1]  <= rdtag;
            end
            if (issue_div) begin
                busy[DIV_LAT-1] <= 1'b1;
                src[DIV_LAT-1]  <= SRC_DIV;
                tag[DIV_LAT-1]  <= rdtag;
                div_cnt         <= CNT_W'(DIV_LAT - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        cdb_valid      = busy[0];
        issue_div_done = busy[0] && (src[0] == SRC_DIV);
        cdb_tagout     = busy[0] ? tag[0] : '0;
        cdb_out        = '0;
        if (busy[0]) begin
            unique case (src[0])
                SRC_INT:  cdb_out = int_data;
                SRC_LD:   cdb_out = ld_buf_data;
                SRC_MULT: cdb_out = mult_data;
                SRC_DIV:  cdb_out = div_data;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed and randomized checking of issue_sched against a
// reference model that books CDB usage in an absolute-cycle calendar.
module tb_issue_sched;

    localparam int ML = 4;
    localparam int DL = 7;

    logic        clk;
    logic        reset;
    logic        ready_int, ready_ld_buf, ready_mult, ready_div;
    logic [5:0]  rdtag;
    logic [31:0] int_data, ld_buf_data, mult_data, div_data;
    logic        issue_int, issue_ld_buf, issue_mult, issue_div;
    logic        issue_div_done, cdb_valid;
    logic [31:0] cdb_out;
    logic [5:0]  cdb_tagout;

    issue_sched #(
        .DATA_W  (32),
        .TAG_W   (6),
        .MULT_LAT(ML),
        .DIV_LAT (DL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ready_int     (ready_int),
        .ready_ld_buf  (ready_ld_buf),
        .ready_mult    (ready_mult),
        .ready_div     (ready_div),
        .rdtag         (rdtag),
        .int_data      (int_data),
        .ld_buf_data   (ld_buf_data),
        .mult_data     (mult_data),
        .div_data      (div_data),
        .issue_int     (issue_int),
        .issue_ld_buf  (issue_ld_buf),
        .issue_mult    (issue_mult),
        .issue_div     (issue_div),
        .issue_div_done(issue_div_done),
        .cdb_valid     (cdb_valid),
        .cdb_out       (cdb_out),
        .cdb_tagout    (cdb_tagout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Calendar of booked CDB cycles, indexed by absolute cycle mod 32.
    bit         ev_busy [32];
    int         ev_src  [32];
    logic [5:0] ev_tag  [32];
    int         cyc     = 0;
    int         div_ok  = 0;
    bit         prefer_ld = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h expected %h", name, cyc, got, exp);
        end
    endtask

    // rdy = {div, mult, ld_buf, int}; exp[4] enables a directed grant check
    // against exp[3:0] in the same order.
    task automatic step(input bit rst, input logic [3:0] rdy, input logic [5:0] t,
                        input logic [4:0] exp);
        logic [31:0] d [4];
        logic [3:0]  g, eg;
        bit          e_int, e_ld, e_mult, e_div, v;
        int          slot, lat, s;

        reset = rst;
        {ready_div, ready_mult, ready_ld_buf, ready_int} = rdy;
        rdtag       = t;
        int_data    = $urandom;
        ld_buf_data = $urandom;
        mult_data   = $urandom;
        div_data    = $urandom;
        d[0] = int_data; d[1] = ld_buf_data; d[2] = mult_data; d[3] = div_data;

        @(negedge clk);

        e_int  = rdy[0] && !ev_busy[(cyc + 1) % 32];
        e_ld   = rdy[1] && !ev_busy[(cyc + 1) % 32];
        e_mult = rdy[2] && !ev_busy[(cyc + ML) % 32];
        e_div  = rdy[3] && !ev_busy[(cyc + DL) % 32] && (cyc >= div_ok);
        eg = 4'b0000;
        if (!rst) begin
            if (e_div)              eg = 4'b1000;
            else if (e_mult)        eg = 4'b0100;
            else if (e_int && e_ld) eg = prefer_ld ? 4'b0010 : 4'b0001;
            else if (e_int)         eg = 4'b0001;
            else if (e_ld)          eg = 4'b0010;
        end

        g = {issue_div, issue_mult, issue_ld_buf, issue_int};
        chk("grant", 32'(g), 32'(eg));
        if (exp[4]) chk("grant_directed", 32'(g), 32'(exp[3:0]));

        if (!rst) begin
            slot = cyc % 32;
            v    = ev_busy[slot];
            chk("cdb_valid", 32'(cdb_valid), 32'(v));
            chk("cdb_tagout", 32'(cdb_tagout), v ? 32'(ev_tag[slot]) : 32'd0);
            chk("cdb_out", cdb_out, v ? d[ev_src[slot]] : 32'd0);
            chk("issue_div_done", 32'(issue_div_done), 32'(v && ev_src[slot] == 3));
        end

        if (rst) begin
            for (int i = 0; i < 32; i++) ev_busy[i] = 1'b0;
            div_ok    = 0;
            prefer_ld = 1'b0;
        end else begin
            ev_busy[cyc % 32] = 1'b0;
            if (eg != 4'b0000) begin
                lat = eg[3] ? DL : (eg[2] ? ML : 1);
                s   = eg[3] ? 3 : (eg[2] ? 2 : (eg[1] ? 1 : 0));
                ev_busy[(cyc + lat) % 32] = 1'b1;
                ev_src[(cyc + lat) % 32]  = s;
                ev_tag[(cyc + lat) % 32]  = t;
                if (eg[3]) div_ok = cyc + DL;
                if (eg[0]) prefer_ld = 1'b1;
                if (eg[1]) prefer_ld = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ready_int = 1'b0; ready_ld_buf = 1'b0; ready_mult = 1'b0; ready_div = 1'b0;
        rdtag = '0;
        int_data = '0; ld_buf_data = '0; mult_data = '0; div_data = '0;
        for (int i = 0; i < 32; i++) ev_busy[i] = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then idle: everything stays quiet.
        step(1'b1, 4'b0000, 6'd0, 5'b1_0000);
        step(1'b1, 4'b1111, 6'd0, 5'b1_0000);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 6'd0, 5'b1_0000);

        // Single int instruction, tag 5, broadcast next cycle.
        step(1'b0, 4'b0001, 6'd5, 5'b1_0001);
        step(1'b0, 4'b0000, 6'd0, 5'b1_0000);

        // Divider held ready: issues at t0 and t0+7 only.
        for (int i = 0; i < 9; i++)
            step(1'b0, 4'b1000, 6'(10 + i), (i == 0 || i == 7) ? 5'b1_1000 : 5'b1_0000);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, 6'd0, 5'b1_0000);

        // Mult at t=0 blocks an int asking at t=3; int goes at t=4.
        step(1'b0, 4'b0100, 6'd20, 5'b1_0100);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);
        step(1'b0, 4'b0001, 6'd21, 5'b1_0000);
        step(1'b0, 4'b0001, 6'd21, 5'b1_0001);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);

        // From reset, int and ld_buf both ready: strict alternation, int first.
        step(1'b1, 4'b0000, 6'd0, 5'b1_0000);
        step(1'b1, 4'b0000, 6'd0, 5'b1_0000);
        step(1'b0, 4'b0011, 6'd30, 5'b1_0001);
        step(1'b0, 4'b0011, 6'd31, 5'b1_0010);
        step(1'b0, 4'b0011, 6'd32, 5'b1_0001);
        step(1'b0, 4'b0011, 6'd33, 5'b1_0010);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);

        // Divide in flight is discarded by reset; a new divide issues at once.
        step(1'b0, 4'b1000, 6'd40, 5'b1_1000);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);
        step(1'b0, 4'b0000, 6'd0,  5'b1_0000);
        step(1'b1, 4'b0000, 6'd0,  5'b1_0000);
        step(1'b0, 4'b1000, 6'd41, 5'b1_1000);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 6'd0, 5'b1_0000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
                 6'($urandom), 5'b0_0000);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 6'd0, 5'b0_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter DATA_W, default 32, CDB data width.
REQ-002 Parameter TAG_W, default 6, destination tag width.
REQ-003 Parameter MULT_LAT, default 4, multiplier issue-to-CDB latency in cycles (pipelined); legal range 2..DIV_LAT-1.
REQ-004 Parameter DIV_LAT, default 7, divider issue-to-CDB latency in cycles (non-pipelined); legal range 3..16.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ready_int / ready_ld_buf / ready_mult / ready_div  in  1 each  queue has an instruction ready to issue.
REQ-008 rdtag  in  TAG_W  destination tag of the instruction issued this cycle.
REQ-009 int_data / ld_buf_data / mult_data / div_data  in  DATA_W each  unit result, valid in the cycle its result is scheduled on the CDB.
REQ-010 issue_int / issue_ld_buf / issue_mult / issue_div  out  1 each  issue grant, combinational, at most one high per cycle.
REQ-011 issue_div_done  out  1  one-cycle pulse in the cycle the divide result is on the CDB.
REQ-012 cdb_valid  out  1  CDB carries a result this cycle (registered).
REQ-013 cdb_out  out  DATA_W  CDB data; cdb_tagout  out  TAG_W  CDB tag.

Function
REQ-014 Latencies SHALL be: int 1, ld_buf 1, mult MULT_LAT, div DIV_LAT; an instruction granted in cycle t SHALL appear on the CDB in cycle t+L.
REQ-015 Reservation vector res[0..DIV_LAT] SHALL hold per slot: busy bit, 2-bit source id, TAG_W tag; res[k] = CDB occupied k cycles from now.
REQ-016 Each edge: res[k] <= res[k+1] for k < DIV_LAT, res[DIV_LAT] <= empty; a grant of latency L additionally writes busy=1, source, rdtag into res[L-1].
REQ-017 A unit of latency L SHALL be eligible only if its ready input is high and res[L].busy is 0.
REQ-018 Divider SHALL additionally be eligible only when div busy counter is 0; counter loads DIV_LAT-1 on issue_div, decrements to 0, saturates at 0.
REQ-019 Priority among eligible units: div > mult > {int, ld_buf}.
REQ-020 int vs ld_buf SHALL be decided by 1-bit LRU: when both eligible and no higher grant, grant the one not granted most recently; LRU updates only on an int or ld_buf grant; reset value selects int first.
REQ-021 When only one of int/ld_buf is eligible it SHALL be granted regardless of LRU.
REQ-022 cdb_valid = res[0].busy; cdb_tagout = res[0].tag; cdb_out = data input selected by res[0].source; cdb_out and cdb_tagout SHALL be 0 when cdb_valid is 0.
REQ-023 issue_div_done SHALL be high iff res[0].busy and res[0].source = div.
REQ-024 No two results SHALL ever occupy the same CDB cycle; at most one grant per cycle.
REQ-025 ready inputs high with no eligibility SHALL produce no grant; the queue holds, no state change except shift.

Reset
REQ-026 While reset is high all grant outputs SHALL be forced to 0.
REQ-027 On a reset edge: all res slots empty, div counter 0, LRU = int-first; next cycle cdb_valid, issue_div_done, cdb_out, cdb_tagout = 0.
REQ-028 Reset mid-operation SHALL discard all in-flight reservations; no CDB broadcast SHALL occur for instructions granted before reset.

Verification (MULT_LAT=4, DIV_LAT=7)
REQ-029 Reset 2 cycles, all ready=0 -> all outputs 0 for 10 cycles.
REQ-030 ready_int=1 cycle t, rdtag=5, int_data=0x1234 at t+1 -> issue_int at t; cdb_valid, cdb_tagout=5, cdb_out=0x1234 at t+1.
REQ-031 ready_div held from t0 -> issue_div at t0 and t0+7 only; issue_div_done and cdb_valid at t0+7 with div_data value.
REQ-032 issue_mult at t=0, ready_int from t=3 -> int blocked at t=3, granted at t=4; CDB: mult at t=4, int at t=5.
REQ-033 ready_int and ready_ld_buf held 4 cycles -> grants int, ld_buf, int, ld_buf.
REQ-034 issue_div at t, reset at t+3 -> no cdb_valid at t+7; ready_div after reset granted immediately.
